result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Downstream of the quantised linear-layer multiplier: consumes the NUM_FEATURES requantised PRECISION-bit results produced per valid cycle.
- Packs consecutive result vectors ("entries") into OUT_WIDTH-bit words and buffers them in a word FIFO.
- Streams the words out over a valid/ready interface, with frame framing (last flag, lane mask).

Parameters:
- PRECISION, 8, bit width of one result.
- NUM_FEATURES, 2, results per entry. Entry width E = NUM_FEATURES*PRECISION.
- OUT_WIDTH, 64, output word width. Must be an integer multiple of E. LANES = OUT_WIDTH/E, which is 4 at the defaults.
- FIFO_DEPTH, 8, output word FIFO depth. Power of two, ≥2.
- FRAME_LEN, 10, entries per frame. ≥1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- in_valid, input, 1, entry present on in_data.
- in_data, input, [NUM_FEATURES-1:0][PRECISION-1:0], result vector; index i is feature i.
- in_ready, output, 1, packer can accept an entry this cycle.
- m_data, output, OUT_WIDTH, packed word.
- m_valid, output, 1, m_data valid.
- m_ready, input, 1, downstream accepts the word.
- m_last, output, 1, word holds the final entry of a frame.
- m_lane_valid, output, LANES, per-lane occupancy of m_data.
- frame_done, output, 1, one-cycle pulse when the last entry of a frame is accepted.
- drop_sticky, output, 1, set when an entry arrives while in_ready=0.
- entries_in_frame, output, $clog2(FRAME_LEN+1), entries of the current frame accepted so far.

Behaviour:
- Reset (rst=0, async) forces the following to 0: m_valid, m_last, m_lane_valid, frame_done, drop_sticky, entries_in_frame, lane counter, pack register, FIFO pointers and count. m_data reads 0. Reset mid-frame discards the partial word and all FIFO contents.
- Accept: entry taken on the rising edge where in_valid && in_ready.
- in_ready = (fifo_count < FIFO_DEPTH). This is registered-state based, with no pop pass-through: when the FIFO is full, in_ready stays 0 even if m_ready=1 in the same cycle.
- Lane placement:
  - Accepted entry goes to lane L (current lane counter), bits [L*E +: E] of the pack word.
  - Feature i sits at bits [L*E + i*PRECISION +: PRECISION].
  - Unused lanes are zero.
- Word completion, on the accepting edge, occurs when L==LANES-1 or the entry is entry FRAME_LEN-1 of the frame. On completion:
  - The completed word (pack register merged with the current entry), lane mask and last flag are written into the FIFO on the same edge.
  - The lane counter returns to 0 and the pack register clears.
  - Otherwise the lane counter increments.
- Frame counter:
  - entries_in_frame increments on each accept.
  - On accepting entry FRAME_LEN-1 it wraps to 0, frame_done pulses high for the following cycle, and the written word carries m_last=1.
  - Lanes restart at 0 for the next frame: words never straddle frames.
- m_lane_valid: bit k=1 iff lane k was filled. A full word is all ones. A frame-final partial word has ones in the low bits only.
- FIFO behaviour:
  - First-word-fall-through.
  - m_valid=1 whenever fifo_count>0; m_data/m_last/m_lane_valid show the head entry.
  - Pop on edge with m_valid && m_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a word written on edge t is visible with m_valid=1 in the cycle after edge t, provided the FIFO was empty.
- Output stability: while m_valid=1 && m_ready=0, m_data/m_last/m_lane_valid hold.
- Overflow:
  - in_valid while in_ready=0: the entry is dropped and drop_sticky sets.
  - drop_sticky is cleared only by reset.
  - The lane counter and frame counter are unaffected by the dropped entry.
- Throughput: one entry per cycle sustained while m_ready=1.

Test Plan:
- Reset then 10 back-to-back entries, entry n = {8'(2n+1), 8'(2n)}, m_ready=1 → 3 words:
  - word0 = 64'h0706_0504_0302_0100, lane_valid=4'b1111, last=0.
  - word1 = 64'h0F0E_0D0C_0B0A_0908, lane_valid=1111, last=0.
  - word2 = 64'h0000_0000_1312_1110, lane_valid=4'b0011, last=1.
  - frame_done pulses once after entry 9; entries_in_frame returns to 0.
- Single entry into an empty FIFO, with entry 3 of a frame arriving in lane 3 → m_valid rises in the cycle after the accepting edge.
- m_ready=0 while streaming 32 entries → in_ready drops once 8 words are queued. Then release m_ready → 8 words drain in order with data intact, no drops, drop_sticky=0.
- FIFO full and in_valid=1 held for 1 cycle → drop_sticky=1. Lane and frame counters unchanged; the next accepted entry lands in the expected lane.
- FIFO at count 4 with simultaneous push and pop for 20 cycles → count stays 4, pointers wrap, output order preserved.
- Assert rst low mid-frame after 6 entries with 1 word queued → all outputs 0 immediately. After release, a fresh 10-entry frame yields exactly the 3-word pattern of the first test.

Source files
------------

// File: rtl/result_packer.sv
// result_packer: packs per-cycle result vectors into wide words and streams them from a FWFT word FIFO with frame framing
module result_packer #(
   parameter int PRECISION    = 8,
   parameter int NUM_FEATURES = 2,
   parameter int OUT_WIDTH    = 64,
   parameter int FIFO_DEPTH   = 8,
   parameter int FRAME_LEN    = 10,
   localparam int E           = NUM_FEATURES * PRECISION,
   localparam int LANES       = OUT_WIDTH / E,
   localparam int FW          = $clog2(FRAME_LEN + 1)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic [NUM_FEATURES-1:0][PRECISION-1:0] in_data,
   output logic                                   in_ready,
   output logic [OUT_WIDTH-1:0]                   m_data,
   output logic                                   m_valid,
   input  logic                                   m_ready,
   output logic                                   m_last,
   output logic [LANES-1:0]                       m_lane_valid,
   output logic                                   frame_done,
   output logic                                   drop_sticky,
   output logic [FW-1:0]                          entries_in_frame
);
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [LW-1:0]        lane_q, lane_d;
   logic [OUT_WIDTH-1:0] pack_q, pack_d, pack_w;
   logic [LANES-1:0]     mask_w;
   logic [FW-1:0]        frame_q, frame_d;
   logic                 frame_done_q, drop_q;
   logic [AW-1:0]        wr_q, rd_q;
   logic [AW:0]          cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [LANES-1:0]     mem_mask [FIFO_DEPTH];
   logic                 mem_last [FIFO_DEPTH];
   logic                 acc, last_ent, done, push, pop;

   // no pop pass-through: a full FIFO refuses input even while it is being drained
   assign in_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
   assign acc      = in_valid && in_ready;
   assign last_ent = frame_q == FW'(FRAME_LEN - 1);
   assign done     = lane_q == LW'(LANES - 1) || last_ent;
   assign push     = acc && done;
   assign m_valid  = cnt_q != '0;
   assign pop      = m_valid && m_ready;

   always_comb begin
      pack_w = pack_q;
      pack_w[lane_q*E +: E] = in_data;
      for (int k = 0; k < LANES; k++) mask_w[k] = k <= int'(lane_q);
      lane_d  = acc ? (done ? '0 : lane_q + LW'(1)) : lane_q;
      pack_d  = acc ? (done ? '0 : pack_w) : pack_q;
      frame_d = acc ? (last_ent ? '0 : frame_q + FW'(1)) : frame_q;
      cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         lane_q       <= '0;
         pack_q       <= '0;
         frame_q      <= '0;
         frame_done_q <= 1'b0;
         drop_q       <= 1'b0;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
      end else begin
         lane_q       <= lane_d;
         pack_q       <= pack_d;
         frame_q      <= frame_d;
         frame_done_q <= acc && last_ent;
         drop_q       <= drop_q | (in_valid && !in_ready);
         cnt_q        <= cnt_d;
         if (push) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
      end

   always_ff @(posedge clk)
      if (push) begin
         mem_data[wr_q] <= pack_w;
         mem_mask[wr_q] <= mask_w;
         mem_last[wr_q] <= last_ent;
      end

   // head is gated so stale storage never shows after reset
   assign m_data           = m_valid ? mem_data[rd_q] : '0;
   assign m_lane_valid     = m_valid ? mem_mask[rd_q] : '0;
   assign m_last           = m_valid && mem_last[rd_q];
   assign frame_done       = frame_done_q;
   assign drop_sticky      = drop_q;
   assign entries_in_frame = frame_q;
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: scoreboard bench for result_packer at default parameters
module tb_result_packer;
   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  m;
      logic        l;
   } word_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [1:0][7:0] in_data = '0;
   logic            in_ready;
   logic [63:0]     m_data;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic            m_last;
   logic [3:0]      m_lane_valid;
   logic            frame_done;
   logic            drop_sticky;
   logic [3:0]      entries_in_frame;

   int    n_cmp = 0, n_err = 0;
   word_t mq[$];
   word_t popped[$];
   word_t w_m;
   logic [63:0] pack_m = '0;
   int    lane_m = 0, frame_m = 0, fd_cnt = 0;
   logic  fd_m = 1'b0, drop_m = 1'b0, mon_en = 1'b0, rdy_m, last_m;

   result_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .m_lane_valid(m_lane_valid), .frame_done(frame_done), .drop_sticky(drop_sticky),
      .entries_in_frame(entries_in_frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ent(input int n);
      return {8'(2*n+1), 8'(2*n)};
   endfunction

   // model of the upcoming rising edge, evaluated on the falling edge before it
   always @(negedge clk) begin
      if (!rst) begin
         if (mon_en) begin
            chk("rst_m_valid", 64'(m_valid), 64'(0));
            chk("rst_m_data", m_data, 64'(0));
            chk("rst_entries", 64'(entries_in_frame), 64'(0));
            chk("rst_drop", 64'(drop_sticky), 64'(0));
         end
         mq.delete();
         pack_m = '0;
         lane_m = 0;
         frame_m = 0;
         fd_m = 1'b0;
         drop_m = 1'b0;
      end else if (mon_en) begin
         rdy_m = mq.size() < 8;
         chk("in_ready", 64'(in_ready), 64'(rdy_m));
         chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
         chk("frame_done", 64'(frame_done), 64'(fd_m));
         chk("entries_in_frame", 64'(entries_in_frame), 64'(frame_m));
         chk("drop_sticky", 64'(drop_sticky), 64'(drop_m));
         if (frame_done) fd_cnt++;
         if (m_valid && m_ready && mq.size() != 0) begin
            w_m = mq.pop_front();
            chk("m_data", m_data, w_m.d);
            chk("m_lane_valid", 64'(m_lane_valid), 64'(w_m.m));
            chk("m_last", 64'(m_last), 64'(w_m.l));
            popped.push_back({m_data, m_lane_valid, m_last});
         end
         fd_m = 1'b0;
         if (in_valid && !rdy_m) drop_m = 1'b1;
         if (in_valid && rdy_m) begin
            last_m = frame_m == 9;
            pack_m[lane_m*16 +: 16] = in_data;
            if (lane_m == 3 || last_m) begin
               w_m.d = pack_m;
               w_m.m = '0;
               for (int k = 0; k <= lane_m; k++) w_m.m[k] = 1'b1;
               w_m.l = last_m;
               mq.push_back(w_m);
               pack_m = '0;
               lane_m = 0;
            end else lane_m++;
            frame_m = last_m ? 0 : frame_m + 1;
            fd_m = last_m;
         end
      end
   end

   task automatic send(input logic [15:0] d);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("send_ready", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      m_ready = 1'b1;
      while (m_valid && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_empty", 64'(m_valid), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic check_frame(input string tag);
      word_t w;
      chk({tag, "_words"}, 64'(popped.size()), 64'(3));
      for (int i = 0; i < 3; i++) begin
         w = i < popped.size() ? popped[i] : '0;
         chk({tag, "_data"}, w.d, i == 0 ? 64'h0706_0504_0302_0100 :
                                  i == 1 ? 64'h0F0E_0D0C_0B0A_0908 : 64'h0000_0000_1312_1110);
         chk({tag, "_mask_last"}, 64'({w.m, w.l}), i == 2 ? 64'b00111 : 64'b11110);
      end
   endtask

   initial begin
      int acc, pops, t;
      do_reset();
      mon_en = 1'b1;
      // back-to-back frame
      m_ready = 1'b1;
      popped.delete();
      fd_cnt = 0;
      for (int i = 0; i < 10; i++) send(ent(i));
      drain();
      check_frame("t1");
      chk("t1_fd_pulses", 64'(fd_cnt), 64'(1));
      chk("t1_entries", 64'(entries_in_frame), 64'(0));
      // latency of a lane-3 completion into an empty FIFO
      for (int i = 0; i < 3; i++) send(ent(i));
      in_valid = 1'b1;
      in_data = ent(3);
      @(negedge clk);
      chk("lat_before", 64'(m_valid), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_after", 64'(m_valid), 64'(1));
      chk("lat_data", m_data, 64'h0706_0504_0302_0100);
      for (int i = 4; i < 10; i++) send(ent(i));
      drain();
      // backpressure fill then release
      m_ready = 1'b0;
      acc = 0;
      while (in_ready && acc < 40) begin
         in_valid = 1'b1;
         in_data = ent(acc);
         @(posedge clk); #1;
         acc++;
      end
      in_valid = 1'b0;
      chk("fill_accepts", 64'(acc), 64'(28));
      chk("fill_in_ready", 64'(in_ready), 64'(0));
      popped.delete();
      drain();
      chk("drain_words", 64'(popped.size()), 64'(8));
      chk("drain_first", popped.size() > 0 ? popped[0].d : '0, 64'h0706_0504_0302_0100);
      for (int i = 28; i < 32; i++) send(ent(i));
      drain();
      chk("no_drop", 64'(drop_sticky), 64'(0));
      // overflow drop
      m_ready = 1'b0;
      t = 0;
      while (in_ready && t < 40) begin
         in_valid = 1'b1;
         in_data = ent(t + 40);
         @(posedge clk); #1;
         t++;
      end
      chk("refill_accepts", 64'(t), 64'(26));
      chk("drop_before", 64'(drop_sticky), 64'(0));
      in_data = 16'hDEAD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("drop_set", 64'(drop_sticky), 64'(1));
      chk("drop_frame", 64'(entries_in_frame), 64'(8));
      drain();
      popped.delete();
      send(16'hBEEF);
      send(16'hCAFE);
      drain();
      chk("post_drop_data", popped.size() > 0 ? popped[0].d : '0, 64'h0000_0000_CAFE_BEEF);
      chk("post_drop_ml", popped.size() > 0 ? 64'({popped[0].m, popped[0].l}) : '0, 64'b00111);
      chk("drop_stays", 64'(drop_sticky), 64'(1));
      // steady state at four words with paired push/pop
      m_ready = 1'b0;
      t = 0;
      while (mq.size() < 4 && t < 40) begin
         in_valid = 1'b1;
         in_data = 16'($urandom);
         @(posedge clk); #1;
         t++;
      end
      acc = 0;
      t = 0;
      while (acc < 20 && t < 200) begin
         in_valid = 1'b1;
         in_data = 16'($urandom);
         m_ready = lane_m == 3 || frame_m == 9;
         if (m_ready) acc++;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      chk("steady_pushes", 64'(acc), 64'(20));
      pops = 0;
      t = 0;
      m_ready = 1'b1;
      while (m_valid && t < 50) begin
         @(posedge clk); #1;
         pops++;
         t++;
      end
      chk("steady_count", 64'(pops), 64'(4));
      // asynchronous reset mid-frame
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(ent(i));
      chk("pre_arst_valid", 64'(m_valid), 64'(1));
      #2 rst = 1'b0;
      #1;
      chk("arst_m_valid", 64'(m_valid), 64'(0));
      chk("arst_m_data", m_data, 64'(0));
      chk("arst_m_last", 64'(m_last), 64'(0));
      chk("arst_lane_valid", 64'(m_lane_valid), 64'(0));
      chk("arst_frame_done", 64'(frame_done), 64'(0));
      chk("arst_entries", 64'(entries_in_frame), 64'(0));
      chk("arst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      m_ready = 1'b1;
      popped.delete();
      fd_cnt = 0;
      for (int i = 0; i < 10; i++) send(ent(i));
      drain();
      check_frame("t6");
      chk("t6_fd_pulses", 64'(fd_cnt), 64'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end
endmodule
